// File: rtl/mc_controller_if.sv
// mc_controller_if: ready-handshaked shared memory port between controller and memory
interface mc_controller_if;
  logic mem_req;
  logic memwrite;
  logic iord;
  logic mem_ready;
  modport master(output mem_req, memwrite, iord, input mem_ready);
  modport slave(input mem_req, memwrite, iord, output mem_ready);
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle CPU control FSM with memory handshake, traps and optional MC_PERF_CNT_EN perf counters
module mc_controller #(
  parameter int OP_W = 4,
  parameter int ALUCTRL_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [OP_W-1:0]      op,
  input  logic                 zero,
  mc_controller_if.master      mem,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic [1:0]           pcsrc,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 halted,
  output logic                 trap,
  output logic [1:0]           trap_cause,
`ifdef MC_PERF_CNT_EN
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          instret_cnt,
`endif
  output logic [3:0]           state_dbg
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, ALUWB = 4'd3, EXEC_I = 4'd4, IWB = 4'd5,
    MEMADR = 4'd6, MEMRD = 4'd7, MEMWB = 4'd8, MEMWR = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
    HALT = 4'd12, TRAP = 4'd13
  } state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [3:0] o4;
  logic illegal, is_req, timeout;
  assign o4 = op[3:0];
  assign illegal = (op >> 4) != '0;
  assign is_req = state == FETCH || state == MEMRD || state == MEMWR;
  assign timeout = is_req && !mem.mem_ready && wait_cnt == CW'(TIMEOUT - 1);
  assign state_dbg = state;
  // state register, wait counter (cleared on any state change or completion) and sticky trap cause
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= FETCH;
      wait_cnt <= '0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_next;
      wait_cnt <= (is_req && !mem.mem_ready && state_next == state) ? wait_cnt + 1'b1 : '0;
      if (state != TRAP && state_next == TRAP) trap_cause <= timeout ? 2'b10 : 2'b01;
    end
  // next-state: ready beats timeout in request states; HALT/TRAP absorb until reset
  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = mem.mem_ready ? DECODE : timeout ? TRAP : FETCH;
      DECODE: state_next = illegal ? TRAP : o4 <= 4'h7 ? EXEC_R : o4 == 4'h8 ? EXEC_I :
                           (o4 == 4'h9 || o4 == 4'hA) ? MEMADR : (o4 == 4'hB || o4 == 4'hC) ? BRANCH :
                           o4 == 4'hD ? JUMP : o4 == 4'hE ? FETCH : HALT;
      EXEC_R: state_next = ALUWB;
      EXEC_I: state_next = IWB;
      MEMADR: state_next = o4 == 4'h9 ? MEMRD : MEMWR;
      MEMRD:  state_next = mem.mem_ready ? MEMWB : timeout ? TRAP : MEMRD;
      MEMWR:  state_next = mem.mem_ready ? FETCH : timeout ? TRAP : MEMWR;
      ALUWB, IWB, MEMWB, BRANCH, JUMP: state_next = FETCH;
      HALT:   state_next = HALT;
      TRAP:   state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end
  // outputs decoded from state; pcwrite/irwrite Mealy-gated; everything forced low while in reset
  always_comb begin
    mem.mem_req = 1'b0;
    mem.memwrite = 1'b0;
    mem.iord = 1'b0;
    irwrite = 1'b0;
    pcwrite = 1'b0;
    pcsrc = 2'b00;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    alucontrol = '0;
    regwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    halted = 1'b0;
    trap = 1'b0;
    if (reset_n)
      case (state)
        FETCH: begin
          mem.mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem.mem_ready;
          pcwrite = mem.mem_ready;
        end
        DECODE: alusrcb = 2'b11;
        EXEC_R: begin
          alusrca = 1'b1;
          alucontrol = ALUCTRL_W'(o4);
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst = 1'b1;
        end
        EXEC_I, MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        IWB: regwrite = 1'b1;
        MEMRD: begin
          mem.mem_req = 1'b1;
          mem.iord = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          mem.mem_req = 1'b1;
          mem.memwrite = 1'b1;
          mem.iord = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          alucontrol = ALUCTRL_W'(4'h1);
          pcsrc = 2'b01;
          pcwrite = o4 == 4'hC ? !zero : zero;
        end
        JUMP: begin
          pcsrc = 2'b10;
          pcwrite = 1'b1;
        end
        HALT: halted = 1'b1;
        TRAP: trap = 1'b1;
        default: ;
      endcase
  end
`ifdef MC_PERF_CNT_EN
  // free-running cycle count while live, retired count on every return to FETCH
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cycle_cnt <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != HALT && state != TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (state != FETCH && state_next == FETCH) instret_cnt <= instret_cnt + 32'd1;
    end
`endif
endmodule
